servo_pwm_decoder: RTL and testbench

- Receive-side counterpart of the pen-servo PWM generator.
- Samples a servo PWM line (looped back from the servo output pin, or driven by a bench) and measures period and high time in 100 us units.
- Classifies the pulse as SERVO_POS_UP, SERVO_POS_DOWN or invalid.
- Used by the processor's pen-state self-check and as a bus monitor in simulation.

---
 rtl/servo_pwm_decoder.sv | 158 +++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_decoder.sv
// Measures period and high time of a servo PWM line in prescaled units and classifies UP/DOWN/invalid.
// Latency: meas_stb 4 clk after pwm_in is first sampled high; no backpressure, results hold until the next strobe.
module servo_pwm_decoder #(
  parameter int CLK_EN_COUNT = 5000,
  parameter int CLK_EN_BITS  = 13,
  parameter int PERIOD       = 200,
  parameter int DUTY_UP      = 10,
  parameter int DUTY_DOWN    = 15,
  parameter int TOL          = 1,
  parameter int CNT_BITS     = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pwm_in,
  output logic                pos,
  output logic                pos_valid,
  output logic                meas_stb,
  output logic [CNT_BITS-1:0] high_units,
  output logic [CNT_BITS-1:0] period_units,
  output logic                fault
);

  localparam logic SERVO_POS_DOWN = 1'b0;
  localparam logic SERVO_POS_UP   = 1'b1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  localparam logic [CNT_BITS-1:0]    CNT_MAX       = '1;
  localparam logic [CNT_BITS-1:0]    TIMEOUT_UNITS = CNT_BITS'(2 * PERIOD);
  localparam logic [CLK_EN_BITS-1:0] PRE_LAST      = CLK_EN_BITS'(CLK_EN_COUNT - 1);
  localparam int unsigned            TOL_U         = TOL;

  logic                   sync1, pwm_s, pwm_d, pwm_q;
  logic                   rise, fall;
  logic [CLK_EN_BITS-1:0] prescaler;
  logic                   tick;
  logic [1:0]             state;
  logic [CNT_BITS-1:0]    period_cnt, high_cnt, high_lat;
  logic [CNT_BITS-1:0]    period_inc, high_inc;
  logic [1:0]             fall_cnt;
  logic                   ok_period, up_hit, down_hit, glitch;

  function automatic logic within_tol(input logic [CNT_BITS-1:0] val, input int unsigned nom);
    int unsigned v;
    int unsigned d;
    v = 32'(val);
    d = (v >= nom) ? v - nom : nom - v;
    return d <= TOL_U;
  endfunction

  // rise/fall are registered; pwm_q is the level aligned so a tick on the fall cycle still counts as high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      pwm_s <= 1'b0;
      pwm_d <= 1'b0;
      pwm_q <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      pwm_s <= sync1;
      pwm_d <= pwm_s;
      pwm_q <= pwm_d;
      rise  <= pwm_s & ~pwm_d;
      fall  <= ~pwm_s & pwm_d;
    end
  end

  assign tick = (prescaler == PRE_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            prescaler <= '0;
    else if (rise || tick) prescaler <= '0;
    else                   prescaler <= prescaler + 1'b1;
  end

  // A tick coinciding with a rise belongs to the period that is ending
  always_comb begin
    period_inc = period_cnt;
    high_inc   = high_cnt;
    if (tick && period_cnt != CNT_MAX)          period_inc = period_cnt + 1'b1;
    if (tick && pwm_q && high_cnt != CNT_MAX)   high_inc   = high_cnt + 1'b1;
  end

  assign ok_period = within_tol(period_inc, PERIOD);
  assign up_hit    = within_tol(high_lat, DUTY_UP);
  assign down_hit  = within_tol(high_lat, DUTY_DOWN);
  assign glitch    = (fall_cnt != 2'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      period_cnt   <= '0;
      high_cnt     <= '0;
      high_lat     <= '0;
      fall_cnt     <= '0;
      pos          <= SERVO_POS_DOWN;
      pos_valid    <= 1'b0;
      meas_stb     <= 1'b0;
      high_units   <= '0;
      period_units <= '0;
      fault        <= 1'b0;
    end else begin
      meas_stb <= 1'b0;
      case (state)
        ST_IDLE, ST_TIMEOUT: begin
          if (rise) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            high_lat   <= '0;
            fall_cnt   <= '0;
            state      <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            meas_stb     <= 1'b1;
            period_units <= period_inc;
            high_units   <= high_lat;
            if (ok_period && !glitch && up_hit) begin
              pos       <= SERVO_POS_UP;
              pos_valid <= 1'b1;
              fault     <= 1'b0;
            end else if (ok_period && !glitch && down_hit) begin
              pos       <= SERVO_POS_DOWN;
              pos_valid <= 1'b1;
              fault     <= 1'b0;
            end else begin
              pos_valid <= 1'b0;
              fault     <= 1'b1;
            end
            period_cnt <= '0;
            high_cnt   <= '0;
            high_lat   <= '0;
            fall_cnt   <= '0;
          end else if (period_inc >= TIMEOUT_UNITS) begin
            period_cnt <= period_inc;
            pos_valid  <= 1'b0;
            fault      <= 1'b1;
            state      <= ST_TIMEOUT;
          end else begin
            period_cnt <= period_inc;
            high_cnt   <= high_inc;
            if (fall) begin
              high_lat <= high_inc;
              if (fall_cnt != 2'd2) fall_cnt <= fall_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with a 4-clk unit so one 200-unit period is 800 clk.
`timescale 1ns/1ps
module tb_servo_pwm_decoder;

  logic       clk;
  logic       reset;
  logic       pwm_in;
  logic       pos;
  logic       pos_valid;
  logic       meas_stb;
  logic [8:0] high_units;
  logic [8:0] period_units;
  logic       fault;

  int total  = 0;
  int passed = 0;
  int stb_cnt = 0;
  int s0;

  servo_pwm_decoder #(.CLK_EN_COUNT(4), .CLK_EN_BITS(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .pwm_in       (pwm_in),
    .pos          (pos),
    .pos_valid    (pos_valid),
    .meas_stb     (meas_stb),
    .high_units   (high_units),
    .period_units (period_units),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (meas_stb === 1'b1) stb_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_meas(input string tag, input int hi, input int per,
                            input logic p, input logic v, input logic f);
    chk({tag, ".high"},   32'(high_units),   hi);
    chk({tag, ".period"}, 32'(period_units), per);
    chk({tag, ".pos"},    32'(pos),          32'(p));
    chk({tag, ".valid"},  32'(pos_valid),    32'(v));
    chk({tag, ".fault"},  32'(fault),        32'(f));
  endtask

  task automatic pulse(input int h, input int p);
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b0;
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst.stb", 32'(meas_stb), 0);
    check_meas("rst", 0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Up position; first rise measures nothing, second shows latency
    pulse(40, 800);
    chk("up1.nostb", stb_cnt, 0);
    pwm_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("lat.n3", 32'(meas_stb), 0);
    @(negedge clk);
    chk("lat.n4", 32'(meas_stb), 1);
    @(negedge clk);
    chk("lat.n5", 32'(meas_stb), 0);
    repeat (35) @(negedge clk);
    pwm_in = 1'b0;
    repeat (760) @(negedge clk);
    chk("up2.stb", stb_cnt, 1);
    check_meas("up2", 10, 200, 1'b1, 1'b1, 1'b0);
    pulse(40, 800);
    chk("up3.stb", stb_cnt, 2);
    check_meas("up3", 10, 200, 1'b1, 1'b1, 1'b0);

    pulse(60, 800);
    pulse(60, 800);
    check_meas("down", 15, 200, 1'b0, 1'b1, 1'b0);
    pulse(40, 800);
    chk("sw1.pos", 32'(pos), 0);
    pulse(40, 800);
    chk("sw2.pos", 32'(pos), 1);

    pulse(60, 800);
    pulse(44, 800);
    pulse(40, 800);
    check_meas("tol11", 11, 200, 1'b1, 1'b1, 1'b0);
    pulse(48, 800);
    pulse(40, 800);
    check_meas("tol12", 12, 200, 1'b1, 1'b0, 1'b1);
    pulse(64, 800);
    pulse(40, 800);
    check_meas("tol16", 16, 200, 1'b0, 1'b1, 1'b0);
    pulse(40, 804);
    pulse(40, 800);
    check_meas("per201", 10, 201, 1'b1, 1'b1, 1'b0);
    pulse(40, 808);
    pulse(40, 800);
    check_meas("per202", 10, 202, 1'b1, 1'b0, 1'b1);

    // Glitch: 5-clk low inside the high phase splits the period
    s0 = stb_cnt;
    pwm_in = 1'b1;
    repeat (20) @(negedge clk);
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    pwm_in = 1'b1;
    repeat (15) @(negedge clk);
    pwm_in = 1'b0;
    repeat (760) @(negedge clk);
    chk("glitch.stb", stb_cnt - s0, 2);
    check_meas("glitch_a", 5, 6, 1'b1, 1'b0, 1'b1);
    pulse(40, 800);
    check_meas("glitch_b", 3, 193, 1'b1, 1'b0, 1'b1);
    pulse(40, 800);
    check_meas("recover", 10, 200, 1'b1, 1'b1, 1'b0);

    // Timeout: line held low after a valid period
    s0 = stb_cnt;
    pwm_in = 1'b1;
    repeat (40) @(negedge clk);
    pwm_in = 1'b0;
    repeat (1556) @(negedge clk);
    chk("to.before_valid", 32'(pos_valid), 1);
    repeat (14) @(negedge clk);
    chk("to.valid", 32'(pos_valid), 0);
    chk("to.fault", 32'(fault), 1);
    chk("to.stb", stb_cnt - s0, 1);
    s0 = stb_cnt;
    pulse(40, 800);
    chk("to.first_rise_nostb", stb_cnt - s0, 0);
    pulse(40, 800);
    chk("to.second_rise_stb", stb_cnt - s0, 1);
    check_meas("after_to", 10, 200, 1'b1, 1'b1, 1'b0);

    // Async reset in the middle of a high phase
    pwm_in = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    check_meas("rst_mid", 0, 0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid.stb", 32'(meas_stb), 0);
    repeat (20) @(negedge clk);
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (750) @(negedge clk);
    s0 = stb_cnt;
    pulse(40, 800);
    chk("rst.first_rise_nostb", stb_cnt - s0, 0);
    pulse(40, 800);
    chk("rst.second_rise_stb", stb_cnt - s0, 1);
    check_meas("after_rst", 10, 200, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
